// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_HOLD,
      ST_DROP
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR_DEF = 32'h00000013;

endpackage

// File: rtl/fetch_skid.sv
// Single-entry park register for a fetched word that ID could not accept yet.
module fetch_skid #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              park,
   input  logic              clr,
   input  logic [DATA_W-1:0] park_data,
   output logic              hold_valid,
   output logic [DATA_W-1:0] hold_data
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_valid <= 1'b0;
         hold_data  <= '0;
      end else if (clr) begin
         hold_valid <= 1'b0;
      end else if (park) begin
         hold_valid <= 1'b1;
         hold_data  <= park_data;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, IF/ID register, redirect handling.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int          PC_W      = 9,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            PcSel,
   input  logic [31:0]     BrPC,
   input  logic            Stall,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic            id_valid,
   output logic [PC_W-1:0] id_pc,
   output logic [31:0]     id_instr
);

   fetch_state_t    state, state_nxt;
   logic [PC_W-1:0] pc;
   logic [31:0]     id_instr_q;
   logic            req_c;
   logic            load;
   logic            from_hold;
   logic            park;
   logic            hold_clr;
   logic            hold_valid;
   logic [31:0]     hold_data;
   logic            slot_free;
   logic            unused_br;

   assign unused_br = ^{BrPC[31:PC_W], BrPC[1:0]};
   assign slot_free = !id_valid || !Stall;

   fetch_skid #(.DATA_W(32)) u_skid (
      .clk        (clk),
      .rst_n      (rst_n),
      .park       (park),
      .clr        (hold_clr),
      .park_data  (imem_rdata),
      .hold_valid (hold_valid),
      .hold_data  (hold_data)
   );

   always_comb begin
      state_nxt = state;
      req_c     = 1'b0;
      load      = 1'b0;
      from_hold = 1'b0;
      park      = 1'b0;
      hold_clr  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!PcSel) begin
               req_c     = 1'b1;
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (PcSel) begin
               state_nxt = imem_rvalid ? ST_IDLE : ST_DROP;
            end else if (imem_rvalid) begin
               if (slot_free) begin
                  load      = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  park      = 1'b1;
                  state_nxt = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (PcSel) begin
               hold_clr  = 1'b1;
               state_nxt = ST_IDLE;
            end else if (!Stall && hold_valid) begin
               load      = 1'b1;
               from_hold = 1'b1;
               hold_clr  = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         // The killed response is the only thing that ends DROP; a further
         // redirect meanwhile only moves the PC.
         ST_DROP: begin
            if (imem_rvalid) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         pc         <= '0;
         id_valid   <= 1'b0;
         id_pc      <= '0;
         id_instr_q <= NOP_INSTR;
      end else begin
         state <= state_nxt;
         if (PcSel) begin
            pc       <= {BrPC[PC_W-1:2], 2'b00};
            id_valid <= 1'b0;
         end else if (load) begin
            pc         <= pc + PC_W'(4);
            id_valid   <= 1'b1;
            id_pc      <= pc;
            id_instr_q <= from_hold ? hold_data : imem_rdata;
         end else if (!Stall) begin
            id_valid <= 1'b0;
         end
      end
   end

   assign imem_req  = rst_n && req_c;
   assign imem_addr = pc;
   assign id_instr  = id_valid ? id_instr_q : NOP_INSTR;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a transaction-level fetch model.
module tb_fetch_stage;

   localparam int          PC_W = 9;
   localparam logic [31:0] NOP  = 32'h00000013;

   logic            clk;
   logic            rst_n;
   logic            PcSel;
   logic [31:0]     BrPC;
   logic            Stall;
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_rvalid;
   logic [31:0]     imem_rdata;
   logic            id_valid;
   logic [PC_W-1:0] id_pc;
   logic [31:0]     id_instr;

   fetch_stage #(.PC_W(PC_W), .NOP_INSTR(NOP)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .PcSel       (PcSel),
      .BrPC        (BrPC),
      .Stall       (Stall),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .id_valid    (id_valid),
      .id_pc       (id_pc),
      .id_instr    (id_instr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model: a request in flight, whether it was killed, and a parked word.
   logic            m_out, m_kill, m_park, m_vld;
   logic [31:0]     m_pdata, m_instr;
   logic [PC_W-1:0] m_pc, m_idpc;

   // Memory: one response countdown with its data.
   int          mem_cnt = 0;
   logic [31:0] mem_data;
   int          lat = 1;

   logic            last_req, last_vld;
   logic [PC_W-1:0] last_addr, last_idpc;
   logic [31:0]     last_instr;

   task automatic model_reset();
      m_out = 0; m_kill = 0; m_park = 0; m_vld = 0;
      m_pdata = '0; m_instr = NOP; m_pc = '0; m_idpc = '0;
   endtask

   task automatic deliver(input logic [31:0] d);
      m_vld   = 1;
      m_idpc  = m_pc;
      m_instr = d;
      m_pc    = m_pc + PC_W'(4);
   endtask

   task automatic model_update(input logic psel, input logic [31:0] br, input logic stl,
                               input logic rv, input logic [31:0] rd);
      logic loaded;
      loaded = 0;
      if (!rst_n) begin
         model_reset();
      end else if (psel) begin
         if (m_out && rv) begin
            m_out = 0; m_kill = 0;
         end else if (m_out) begin
            m_kill = 1;
         end
         m_park = 0;
         m_vld  = 0;
         m_pc   = {br[PC_W-1:2], 2'b00};
      end else begin
         if (!m_out && !m_park) begin
            m_out = 1;
         end else if (m_out && rv) begin
            m_out = 0;
            if (m_kill) m_kill = 0;
            else if (!m_vld || !stl) begin deliver(rd); loaded = 1; end
            else begin m_park = 1; m_pdata = rd; end
         end else if (m_park && !stl) begin
            m_park = 0;
            deliver(m_pdata);
            loaded = 1;
         end
         if (!loaded && !stl) m_vld = 0;
      end
   endtask

   // One clock cycle; entered and left just after a rising edge.
   task automatic step(input logic psel, input logic [31:0] br, input logic stl);
      logic exp_req;
      PcSel = psel; BrPC = br; Stall = stl;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (mem_cnt > 0) begin
         mem_cnt--;
         if (mem_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_data;
         end
      end
      #4;
      exp_req = rst_n && !m_out && !m_park && !psel;
      chk("req", imem_req, exp_req);
      if (exp_req) chk("addr", imem_addr, m_pc);
      chk("vld", id_valid, m_vld);
      chk("idpc", id_pc, m_idpc);
      chk("instr", id_instr, m_vld ? m_instr : NOP);
      last_req = imem_req; last_addr = imem_addr; last_vld = id_valid;
      last_idpc = id_pc; last_instr = id_instr;
      if (imem_req) begin
         mem_cnt  = lat;
         mem_data = $urandom;
      end
      model_update(psel, br, stl, imem_rvalid, imem_rdata);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; PcSel = 0; BrPC = '0; Stall = 0;
      imem_rvalid = 0; imem_rdata = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_vld", id_valid, 0);
      chk("rst_idpc", id_pc, 0);
      chk("rst_instr", id_instr, NOP);
      chk("rst_req", imem_req, 0);
      rst_n = 1'b1;

      // Back-to-back fetches, latency 1
      lat = 1;
      step(0, 0, 0); chk("first_req", last_req, 1); chk("first_addr", last_addr, 9'h000);
      step(0, 0, 0);
      step(0, 0, 0); chk("addr4", last_addr, 9'h004); chk("idpc0", last_idpc, 9'h000);
      step(0, 0, 0);
      // Stall while the 0x008 response lands
      step(0, 0, 1); chk("addr8", last_addr, 9'h008); chk("idpc4", last_idpc, 9'h004);
      step(0, 0, 1);
      step(0, 0, 1); chk("hold_noreq", last_req, 0); chk("hold_idpc", last_idpc, 9'h004);
      step(0, 0, 0);
      lat = 2;
      step(0, 0, 0); chk("idpc8", last_idpc, 9'h008); chk("addrC", last_addr, 9'h00C);
      // Redirect while waiting; the late response must be dropped
      step(1, 32'h40, 0); chk("redir_noreq", last_req, 0);
      lat = 1;
      step(0, 0, 0); chk("drop_vld", last_vld, 0); chk("drop_noreq", last_req, 0);
      step(0, 0, 0); chk("addr40", last_addr, 9'h040); chk("after_drop_vld", last_vld, 0);
      step(0, 0, 0);
      // Redirect beats a stalled valid slot
      step(1, 32'h80, 1);
      step(0, 0, 0); chk("flush_vld", last_vld, 0); chk("flush_instr", last_instr, NOP);
      chk("addr80", last_addr, 9'h080);
      // PC wrap and truncation of the redirect target
      step(1, 32'h1FC, 0);
      step(0, 0, 0); chk("addr1FC", last_addr, 9'h1FC);
      step(0, 0, 0);
      step(0, 0, 0); chk("wrap_addr", last_addr, 9'h000); chk("wrap_idpc", last_idpc, 9'h1FC);
      step(1, 32'h0000_0203, 0);
      lat = 3;
      step(0, 0, 0); chk("trunc_addr", last_addr, 9'h000);
      // Reset while a response is in flight
      step(0, 0, 0);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("mid_rst_vld", id_valid, 0);
      chk("mid_rst_req", imem_req, 0);
      chk("mid_rst_instr", id_instr, NOP);
      step(0, 0, 0);
      rst_n = 1'b1;
      lat = 1;
      step(0, 0, 0); chk("post_rst_addr", last_addr, 9'h000); chk("post_rst_req", last_req, 1);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         logic        ps, st;
         logic [31:0] br;
         ps  = ($urandom_range(0, 9) == 0);
         st  = ($urandom_range(0, 2) == 0);
         br  = $urandom;
         if ($urandom_range(0, 3) == 0) br = {{(32-PC_W){1'b0}}, m_pc};
         lat = $urandom_range(1, 3);
         if ($urandom_range(0, 299) == 0) begin
            rst_n = 1'b0;
            model_reset();
         end else begin
            rst_n = 1'b1;
         end
         step(ps, br, st);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
